isqrt_arbiter: RTL



---
 rtl/isqrt_arb_pkg.sv | 10 +
 rtl/isqrt_arb_tag_fifo.sv | 64 ++++++
 rtl/isqrt_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/isqrt_arb_pkg.sv
// Shared types and limits for the isqrt arbiter slice.
package isqrt_arb_pkg;

    localparam int N_REQ_MAX = 8;

    typedef logic [$clog2(N_REQ_MAX)-1:0] tag_t;
    typedef logic [31:0]                  isqrt_x_t;
    typedef logic [15:0]                  isqrt_y_t;

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding isqrt op.
// Pointers wrap explicitly, so DEPTH need not be a power of two.
// A pop while empty is ignored; the parent flags that case.
module isqrt_arb_tag_fifo
    import isqrt_arb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  tag_t          din,
    output tag_t          dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only taken when a pop frees the slot.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage.
    // NOTE: the storage array is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/isqrt_arbiter.sv
// Shares one pipelined isqrt between N_REQ requesters and routes results back by tag.
// Optional macro ISQRT_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round robin.
module isqrt_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ*32-1:0] req_x,
    output logic [N_REQ-1:0]   req_rdy,
    output logic [N_REQ-1:0]   rsp_vld,
    output logic [15:0]        rsp_y,
    output logic               isqrt_x_vld,
    output logic [31:0]        isqrt_x,
    input  logic               isqrt_y_vld,
    input  logic [15:0]        isqrt_y,
    output logic               err_orphan
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          can_issue;
    logic          gnt_found;
    logic          gnt_vld;
    tag_t          gnt_idx;
    tag_t          tag_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop_ok;
    logic [N_REQ-1:0] rsp_next;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept an issue.
    assign can_issue = (fifo_count < CW'(FIFO_DEPTH)) | isqrt_y_vld;
    assign gnt_vld   = gnt_found & can_issue;
    assign pop_ok    = isqrt_y_vld & ~fifo_empty;

`ifdef ISQRT_ARB_FIXED_PRIO_EN
    // Fixed priority search: lowest valid index wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_vld[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = tag_t'(i);
            end
        end
    end
`else
    tag_t               ptr;
    logic [2*N_REQ-1:0] req_dbl;

    // Round-robin search: rotate the request vector so the search starts at ptr.
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        req_dbl   = {req_vld, req_vld} >> ptr;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!gnt_found && req_dbl[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = (int'(ptr) + j >= N_REQ) ? tag_t'(int'(ptr) + j - N_REQ)
                                                     : tag_t'(int'(ptr) + j);
            end
        end
    end

    // Round-robin pointer: moves just past the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == tag_t'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    // Issue mux: one-hot grant and operand select.
    always_comb begin
        req_rdy     = '0;
        isqrt_x_vld = gnt_vld;
        isqrt_x     = 'x;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vld && gnt_idx == tag_t'(i)) begin
                req_rdy[i] = 1'b1;
                isqrt_x    = req_x[32*i +: 32];
            end
        end
    end

    isqrt_arb_tag_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_vld),
        .pop   (isqrt_y_vld),
        .din   (gnt_idx),
        .dout  (tag_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A push on a full FIFO must be matched by a pop in the same cycle.
    assert property (@(posedge clk) disable iff (rst) (fifo_full && gnt_vld) |-> pop_ok);

    // Decode the head tag into the one-hot response valid.
    always_comb begin
        rsp_next = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_next[i] = pop_ok && (tag_head == tag_t'(i));
        end
    end

    // Response register and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld    <= '0;
            rsp_y      <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_vld <= rsp_next;
            if (pop_ok) rsp_y <= isqrt_y;
            if (isqrt_y_vld && fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule
